tlb_ctrl: RTL

Sequencer placed in front of the 32-entry fully associative TLB CAM (`Registers`). It accepts one translation request at a time and runs the CAM lookup. On a miss it requests a page-table walk, then writes the returned PTE into a victim entry chosen by an invalid-first, round-robin policy, and returns PPN and permissions. It also runs the flush sequence, which zeroes all 32 entries.

---
 rtl/tlb_ctrl_if.sv | 52 +++++
 rtl/tlb_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tlb_ctrl_if.sv
// Bus bundle between the TLB sequencer, its requester, the page-table walker and the TLB CAM.
interface tlb_ctrl_if #(
  parameter int unsigned VPN_W = 20,
  parameter int unsigned PPN_W = 22,
  parameter int unsigned PTE_W = 32,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned TLB_W = 52
);
  // Requester side
  logic             req_valid;
  logic             req_ready;
  logic [VPN_W-1:0] req_vpn;
  logic             resp_valid;
  logic [PPN_W-1:0] resp_ppn;
  logic [3:0]       resp_perm;
  logic             resp_fault;
  // Page-table walker side
  logic             ptw_req_valid;
  logic [VPN_W-1:0] ptw_req_vpn;
  logic             ptw_resp_valid;
  logic [PTE_W-1:0] ptw_resp_pte;
  logic             ptw_resp_fault;
  // Flush control
  logic             flush;
  logic             flush_busy;
  // CAM side
  logic             cam_re;
  logic [VPN_W-1:0] cam_vpn;
  logic             cam_we;
  logic [IDX_W-1:0] cam_write_addr;
  logic [TLB_W-1:0] cam_write_data;
  logic             cam_miss;
  logic             cam_valid_data;
  logic [PPN_W+3:0] cam_output_data;
  logic [IDX_W-1:0] cam_access_addr;

  // The sequencer itself
  modport slave (
    input  req_valid, req_vpn, ptw_resp_valid, ptw_resp_pte, ptw_resp_fault, flush,
           cam_miss, cam_valid_data, cam_output_data, cam_access_addr,
    output req_ready, resp_valid, resp_ppn, resp_perm, resp_fault, ptw_req_valid,
           ptw_req_vpn, flush_busy, cam_re, cam_vpn, cam_we, cam_write_addr, cam_write_data
  );

  // Everything surrounding the sequencer
  modport master (
    output req_valid, req_vpn, ptw_resp_valid, ptw_resp_pte, ptw_resp_fault, flush,
           cam_miss, cam_valid_data, cam_output_data, cam_access_addr,
    input  req_ready, resp_valid, resp_ppn, resp_perm, resp_fault, ptw_req_valid,
           ptw_req_vpn, flush_busy, cam_re, cam_vpn, cam_we, cam_write_addr, cam_write_data
  );
endinterface

// File: rtl/tlb_ctrl.sv
// TLB sequencer: CAM lookup, page-table walk on miss, victim fill, and 32-entry flush sweep.
module tlb_ctrl #(
  parameter int unsigned VPN_W   = 20,
  parameter int unsigned PPN_W   = 22,
  parameter int unsigned PTE_W   = 32,
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned TLB_W   = 52
) (
  input logic        clk,
  input logic        rst,
  tlb_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLookup, StWalk, StFill, StFault, StFlush} state_e;

  state_e             state_q, state_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic [PTE_W-1:0]   pte_q, pte_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               flush_pending_q, flush_pending_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_fault_q, resp_fault_d;
  logic [PPN_W-1:0]   resp_ppn_q, resp_ppn_d;
  logic [3:0]         resp_perm_q, resp_perm_d;

  logic               flush_now;
  logic               req_ready;
  logic               accept;
  logic [IDX_W-1:0]   victim;
  logic               shadow_full;
  logic               cam_we;
  logic [IDX_W-1:0]   cam_write_addr;
  logic [TLB_W-1:0]   cam_write_data;

  // A flush pulse in the same IDLE cycle as a request already wins over it.
  assign flush_now   = flush_pending_q | bus.flush;
  assign req_ready   = (state_q == StIdle) && !flush_now;
  assign accept      = bus.req_valid && req_ready;
  assign shadow_full = &valid_q;

  // Victim: lowest-indexed invalid entry, else the round-robin pointer.
  always_comb begin
    victim = rr_q;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) victim = IDX_W'(i);
    end
  end

  // Next-state, CAM write port and response registers.
  always_comb begin
    state_d         = state_q;
    vpn_d           = vpn_q;
    pte_d           = pte_q;
    valid_d         = valid_q;
    rr_d            = rr_q;
    flush_cnt_d     = flush_cnt_q;
    flush_pending_d = flush_pending_q | bus.flush;
    resp_valid_d    = 1'b0;
    resp_fault_d    = resp_fault_q;
    resp_ppn_d      = resp_ppn_q;
    resp_perm_d     = resp_perm_q;
    cam_we          = 1'b0;
    cam_write_addr  = '0;
    cam_write_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (flush_now) begin
          // Entering the sweep consumes the pending flush and forgets all entries.
          state_d         = StFlush;
          flush_pending_d = 1'b0;
          valid_d         = '0;
          rr_d            = '0;
          flush_cnt_d     = '0;
        end else if (accept) begin
          vpn_d   = bus.req_vpn;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (bus.cam_valid_data) begin
          resp_valid_d = 1'b1;
          resp_ppn_d   = bus.cam_output_data[PPN_W+3:4];
          resp_perm_d  = bus.cam_output_data[3:0];
          resp_fault_d = 1'b0;
          state_d      = StIdle;
        end else if (bus.cam_miss) begin
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (bus.ptw_resp_valid) begin
          if (bus.ptw_resp_fault || !bus.ptw_resp_pte[0]) begin
            state_d = StFault;
          end else begin
            pte_d   = bus.ptw_resp_pte;
            state_d = StFill;
          end
        end
      end
      StFill: begin
        cam_we          = 1'b1;
        cam_write_addr  = victim;
        cam_write_data  = {vpn_q, pte_q};
        valid_d[victim] = 1'b1;
        if (shadow_full) rr_d = rr_q + 1'b1;
        resp_valid_d    = 1'b1;
        resp_ppn_d      = pte_q[PTE_W-1:10];
        resp_perm_d     = pte_q[4:1];
        resp_fault_d    = 1'b0;
        state_d         = StIdle;
      end
      StFault: begin
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b1;
        resp_ppn_d   = '0;
        resp_perm_d  = '0;
        state_d      = StIdle;
      end
      StFlush: begin
        cam_we         = 1'b1;
        cam_write_addr = flush_cnt_q;
        flush_cnt_d    = flush_cnt_q + 1'b1;
        if (flush_cnt_q == IDX_W'(ENTRIES - 1)) begin
          flush_cnt_d = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      vpn_q           <= '0;
      pte_q           <= '0;
      valid_q         <= '0;
      rr_q            <= '0;
      flush_cnt_q     <= '0;
      flush_pending_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_fault_q    <= 1'b0;
      resp_ppn_q      <= '0;
      resp_perm_q     <= '0;
    end else begin
      state_q         <= state_d;
      vpn_q           <= vpn_d;
      pte_q           <= pte_d;
      valid_q         <= valid_d;
      rr_q            <= rr_d;
      flush_cnt_q     <= flush_cnt_d;
      flush_pending_q <= flush_pending_d;
      resp_valid_q    <= resp_valid_d;
      resp_fault_q    <= resp_fault_d;
      resp_ppn_q      <= resp_ppn_d;
      resp_perm_q     <= resp_perm_d;
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_ppn       = resp_ppn_q;
  assign bus.resp_perm      = resp_perm_q;
  assign bus.resp_fault     = resp_fault_q;
  assign bus.ptw_req_valid  = (state_q == StWalk);
  assign bus.ptw_req_vpn    = vpn_q;
  assign bus.flush_busy     = flush_pending_q | (state_q == StFlush);
  assign bus.cam_re         = accept;
  assign bus.cam_vpn        = accept ? bus.req_vpn : vpn_q;
  assign bus.cam_we         = cam_we;
  assign bus.cam_write_addr = cam_write_addr;
  assign bus.cam_write_data = cam_write_data;

endmodule
